// File: rtl/svc_uart_rx_frame_pkg.sv
// Shared constants and types for the 8N1 receive framer.
package svc_uart_rx_frame_pkg;

    // 8N1 frame: eight data bits, LSB first, one stop bit, no parity.
    localparam int DATA_BITS = 8;

    // Below four clocks per bit there is no usable mid-bit sample point.
    localparam int MIN_CLKS_PER_BIT = 4;

    typedef logic [DATA_BITS-1:0] rx_byte_t;

endpackage

// File: rtl/svc_uart_rx_frame_if.sv
// Registered valid/ready byte stream out of the receive framer.
interface svc_uart_rx_frame_if;
    import svc_uart_rx_frame_pkg::*;

    logic     urx_valid;
    rx_byte_t urx_data;
    logic     urx_ready;

    modport master (
        output urx_valid,
        output urx_data,
        input  urx_ready
    );

    modport slave (
        input  urx_valid,
        input  urx_data,
        output urx_ready
    );

endinterface

// File: rtl/svc_sync_bit.sv
// Generic two-flop synchroniser for a single asynchronous input bit.
module svc_sync_bit #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; both come out of reset at the idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/svc_uart_rx_frame.sv
// Receive-side UART framer: 8N1, LSB first, mid-bit sampling, with
// single-cycle framing and overrun error pulses.
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge
// START     | timing to the centre of the start bit to reject glitches
// DATA      | sampling the eight data bits at their centres
// STOP      | sampling the stop bit, delivering or dropping the byte
// WAIT_HIGH | stop bit was low; waiting for the line to return high
module svc_uart_rx_frame
    import svc_uart_rx_frame_pkg::*;
#(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       urx_pin,
    svc_uart_rx_frame_if.master        urx_bus,
    output logic                       frame_err,
    output logic                       overrun_err
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] HALF_TC  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_TC  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_IDX = 3'(DATA_BITS - 1);

    if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_cpb_check
        $fatal(1, "svc_uart_rx_frame: CLOCK_FREQ/BAUD_RATE must be at least 4");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             rx_s;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       idx;
    rx_byte_t         shreg;
    logic             valid_q;
    rx_byte_t         data_q;
    logic             half_tc;
    logic             bit_tc;
    logic             o_free;

    svc_sync_bit #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (urx_pin),
        .q     (rx_s)
    );

    assign half_tc = (bit_cnt == HALF_TC);
    assign bit_tc  = (bit_cnt == FULL_TC);
    // The output slot can take a new byte if empty or being drained this cycle.
    assign o_free  = !valid_q || urx_bus.urx_ready;

    assign urx_bus.urx_valid = valid_q;
    assign urx_bus.urx_data  = data_q;

    // Frame-level state transitions, driven only by the synchronised line.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!rx_s)   state_nxt = START;
            START:     if (half_tc) state_nxt = rx_s ? IDLE : DATA;
            DATA:      if (bit_tc && (idx == LAST_IDX)) state_nxt = STOP;
            STOP:      if (bit_tc)  state_nxt = rx_s ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s)    state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Bit timing, shift register, output slot and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            idx         <= '0;
            shreg       <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;

            // Consumer drain; a byte landing this same cycle overrides it below.
            if (valid_q && urx_bus.urx_ready) begin
                valid_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                end
                START: begin
                    if (half_tc) begin
                        bit_cnt <= '0;
                        idx     <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_tc) begin
                        bit_cnt <= '0;
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        idx     <= idx + 3'd1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_tc) begin
                        bit_cnt <= '0;
                        if (rx_s) begin
                            if (o_free) begin
                                valid_q <= 1'b1;
                                data_q  <= shreg;
                            end else begin
                                overrun_err <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    bit_cnt <= '0;
                end
                default: begin
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_svc_uart_rx_frame.sv
// Self-checking bench for svc_uart_rx_frame at 8 clocks per bit.
module tb_svc_uart_rx_frame;

    localparam int CLOCK_FREQ = 100_000_000;
    localparam int BAUD_RATE  = 12_500_000;
    localparam int CPB        = CLOCK_FREQ / BAUD_RATE;
    // Line start edge to stop-bit mid-sample: two synchroniser clocks, half a
    // bit to the start-bit centre, then nine whole bits.
    localparam int STOP_OFS   = 2 + CPB / 2 + 9 * CPB;

    logic clk         = 1'b0;
    logic rst_n       = 1'b0;
    logic urx_pin     = 1'b1;
    logic frame_err;
    logic overrun_err;

    svc_uart_rx_frame_if urx_bus();

    svc_uart_rx_frame #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .urx_pin    (urx_pin),
        .urx_bus    (urx_bus),
        .frame_err  (frame_err),
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // Per-cycle line and ready schedule, plus stop-sample events keyed by cycle.
    bit         pin_q[$];
    bit         rdy_q[$];
    bit         ev_ok[int];
    logic [7:0] ev_dat[int];
    int         rdy_pct = 100;

    // Reference model of the output slot.
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;

    // Observations from the last play.
    int         n_xfer;
    int         n_ferr;
    int         n_ovr;
    logic [7:0] xfer_q[$];

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        int         exp_xfer;
        int         exp_ferr;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] nth_xfer(input int i);
        if (i < xfer_q.size()) return xfer_q[i];
        return 8'hxx;
    endfunction

    task automatic clear_sched();
        pin_q.delete();
        rdy_q.delete();
        ev_ok.delete();
        ev_dat.delete();
    endtask

    task automatic push(input bit p);
        pin_q.push_back(p);
        rdy_q.push_back($urandom_range(0, 99) < rdy_pct);
    endtask

    task automatic add_idle(input int n);
        repeat (n) push(1'b1);
    endtask

    task automatic add_frame(input logic [7:0] d, input bit ok);
        int s;
        s = pin_q.size();
        repeat (CPB) push(1'b0);
        for (int i = 0; i < 8; i++) repeat (CPB) push(d[i]);
        repeat (CPB) push(ok);
        ev_ok[s + STOP_OFS]  = ok;
        ev_dat[s + STOP_OFS] = d;
    endtask

    task automatic add_glitch(input int n);
        repeat (n) push(1'b0);
    endtask

    // A held-low line looks like a 0x00 frame whose stop bit is low.
    task automatic add_break(input int nbits);
        int s;
        s = pin_q.size();
        repeat (nbits * CPB) push(1'b0);
        ev_ok[s + STOP_OFS]  = 1'b0;
        ev_dat[s + STOP_OFS] = 8'h00;
    endtask

    // Drive the schedule cycle by cycle and compare against the slot model.
    task automatic play(input string tag, input int len);
        int  n;
        bit  r;
        bit  free;
        bit  ef;
        bit  eo;
        n = (len < 0 || len > pin_q.size()) ? pin_q.size() : len;
        n_xfer = 0;
        n_ferr = 0;
        n_ovr  = 0;
        xfer_q.delete();
        for (int c = 0; c < n; c++) begin
            r = rdy_q[c];
            urx_pin           = pin_q[c];
            urx_bus.urx_ready = r;
            if (urx_bus.urx_valid && r) begin
                n_xfer++;
                xfer_q.push_back(urx_bus.urx_data);
            end
            free = !m_valid || r;
            ef   = 1'b0;
            eo   = 1'b0;
            if (m_valid && r) m_valid = 1'b0;
            if (ev_ok.exists(c)) begin
                if (ev_ok[c]) begin
                    if (free) begin
                        m_valid = 1'b1;
                        m_data  = ev_dat[c];
                    end else begin
                        eo = 1'b1;
                    end
                end else begin
                    ef = 1'b1;
                end
            end
            @(posedge clk);
            @(negedge clk);
            chk({tag, ".valid"}, c, 32'(urx_bus.urx_valid), 32'(m_valid));
            chk({tag, ".data"}, c, 32'(urx_bus.urx_data), 32'(m_data));
            chk({tag, ".frame_err"}, c, 32'(frame_err), 32'(ef));
            chk({tag, ".overrun_err"}, c, 32'(overrun_err), 32'(eo));
            if (frame_err) n_ferr++;
            if (overrun_err) n_ovr++;
        end
    endtask

    initial begin
        int s2;
        int n_good;
        int n_bad;
        logic [7:0] d;
        bit ok;

        vt[0] = '{8'hB0, 1'b1, 1, 0};
        vt[1] = '{8'h00, 1'b1, 1, 0};
        vt[2] = '{8'hFF, 1'b1, 1, 0};
        vt[3] = '{8'hA5, 1'b1, 1, 0};
        vt[4] = '{8'h55, 1'b0, 0, 1};
        vt[5] = '{8'h01, 1'b1, 1, 0};
        vt[6] = '{8'h80, 1'b1, 1, 0};
        vt[7] = '{8'hC3, 1'b0, 0, 1};

        urx_bus.urx_ready = 1'b0;
        #1;
        chk("reset.valid", 0, 32'(urx_bus.urx_valid), 32'd0);
        chk("reset.data", 0, 32'(urx_bus.urx_data), 32'd0);
        chk("reset.frame_err", 0, 32'(frame_err), 32'd0);
        chk("reset.overrun_err", 0, 32'(overrun_err), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single frames with the consumer always ready.
        for (int i = 0; i < 8; i++) begin
            clear_sched();
            rdy_pct = 100;
            add_idle(3);
            add_frame(vt[i].data, vt[i].stop_ok);
            add_idle(12);
            play("vec", -1);
            chk("vec.n_xfer", i, 32'(n_xfer), 32'(vt[i].exp_xfer));
            chk("vec.n_ferr", i, 32'(n_ferr), 32'(vt[i].exp_ferr));
            chk("vec.n_ovr", i, 32'(n_ovr), 32'd0);
            if (vt[i].exp_xfer == 1) chk("vec.byte", i, 32'(nth_xfer(0)), 32'(vt[i].data));
        end

        // Back-pressure: second byte overruns, first is kept.
        clear_sched();
        rdy_pct = 0;
        add_idle(2);
        add_frame(8'hB0, 1'b1);
        add_frame(8'hF0, 1'b1);
        add_idle(4);
        rdy_pct = 100;
        add_idle(6);
        play("bp", -1);
        chk("bp.n_ovr", 0, 32'(n_ovr), 32'd1);
        chk("bp.n_xfer", 0, 32'(n_xfer), 32'd1);
        chk("bp.byte", 0, 32'(nth_xfer(0)), 32'hB0);
        chk("bp.valid_end", 0, 32'(urx_bus.urx_valid), 32'd0);

        // Accept and arrive in the same cycle.
        clear_sched();
        rdy_pct = 0;
        add_idle(2);
        add_frame(8'hB0, 1'b1);
        s2 = pin_q.size();
        add_frame(8'hF0, 1'b1);
        add_idle(10);
        rdy_q[s2 + STOP_OFS] = 1'b1;
        rdy_pct = 100;
        add_idle(5);
        play("same", -1);
        chk("same.n_ovr", 0, 32'(n_ovr), 32'd0);
        chk("same.n_xfer", 0, 32'(n_xfer), 32'd2);
        chk("same.byte0", 0, 32'(nth_xfer(0)), 32'hB0);
        chk("same.byte1", 0, 32'(nth_xfer(1)), 32'hF0);

        // Framing error followed by a good byte.
        clear_sched();
        rdy_pct = 100;
        add_idle(2);
        add_frame(8'h55, 1'b0);
        add_idle(20);
        add_frame(8'hAB, 1'b1);
        add_idle(20);
        play("frm", -1);
        chk("frm.n_ferr", 0, 32'(n_ferr), 32'd1);
        chk("frm.n_xfer", 0, 32'(n_xfer), 32'd1);
        chk("frm.byte", 0, 32'(nth_xfer(0)), 32'hAB);

        // Glitch, then a 30-bit break, then a clean byte.
        clear_sched();
        rdy_pct = 100;
        add_idle(5);
        add_glitch(3);
        add_idle(20);
        add_break(30);
        add_idle(20);
        add_frame(8'h01, 1'b1);
        add_idle(20);
        play("brk", -1);
        chk("brk.n_ferr", 0, 32'(n_ferr), 32'd1);
        chk("brk.n_xfer", 0, 32'(n_xfer), 32'd1);
        chk("brk.byte", 0, 32'(nth_xfer(0)), 32'h01);
        chk("brk.n_ovr", 0, 32'(n_ovr), 32'd0);

        // Random frames, stop bits and consumer back-pressure.
        clear_sched();
        n_good  = 0;
        n_bad   = 0;
        rdy_pct = 100;
        add_idle(4);
        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 4))
                0:       rdy_pct = 0;
                1:       rdy_pct = 10;
                2:       rdy_pct = 50;
                3:       rdy_pct = 90;
                default: rdy_pct = 100;
            endcase
            d  = 8'($urandom);
            ok = ($urandom_range(0, 9) != 0);
            add_frame(d, ok);
            if (ok) n_good++;
            else n_bad++;
            add_idle(ok ? $urandom_range(0, 12) : $urandom_range(2, 12));
        end
        rdy_pct = 100;
        add_idle(20);
        play("rand", -1);
        chk("rand.n_ferr", 0, 32'(n_ferr), 32'(n_bad));
        chk("rand.delivered", 0, 32'(n_xfer + n_ovr), 32'(n_good));

        // Reset during data bit 3 while a byte is held.
        clear_sched();
        rdy_pct = 0;
        add_idle(2);
        add_frame(8'hB0, 1'b1);
        add_idle(4);
        s2 = pin_q.size();
        add_frame(8'h3C, 1'b1);
        play("rstpre", s2 + 4 * CPB + 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.valid", 0, 32'(urx_bus.urx_valid), 32'd0);
        chk("rst.data", 0, 32'(urx_bus.urx_data), 32'd0);
        chk("rst.frame_err", 0, 32'(frame_err), 32'd0);
        chk("rst.overrun_err", 0, 32'(overrun_err), 32'd0);
        m_valid = 1'b0;
        m_data  = 8'h00;
        urx_pin = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_sched();
        rdy_pct = 100;
        add_idle(4);
        add_frame(8'h7E, 1'b1);
        add_idle(10);
        play("rstpost", -1);
        chk("rstpost.n_xfer", 0, 32'(n_xfer), 32'd1);
        chk("rstpost.byte", 0, 32'(nth_xfer(0)), 32'h7E);
        chk("rstpost.n_ferr", 0, 32'(n_ferr), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
